// File: rtl/ip_mem_pkg.sv
// ip_mem shared constants: widths and the I/O page map.
// Also used by the LSU decoder.
package ip_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PAGE_W = ADDR_W - 4;

  localparam logic [PAGE_W-1:0] SW_BASE  = 12'h780;
  localparam logic [PAGE_W-1:0] BTN_BASE = 12'h781;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SW   = 2'd1,
    SEL_BTN  = 2'd2
  } ip_sel_e;

  // Select a peripheral register from the 16-byte page number.
  function automatic ip_sel_e ip_decode(
    input logic [PAGE_W-1:0] page
  );
    ip_sel_e sel;
    sel = SEL_NONE;
    if (page == SW_BASE)
      sel = SEL_SW;
    else if (page == BTN_BASE)
      sel = SEL_BTN;
    return sel;
  endfunction

endpackage

// File: rtl/ip_mem_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs.
// Output is the second stage; clears synchronously on rst_i.
module sync_2ff
  import ip_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sync_q;

  // Two back-to-back stages; reset wins over sampling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ip_mem.sv
// ip_mem: read-only switch/button page on the data bus.
// Inputs are synchronized; reads decode combinationally.
module ip_mem
  import ip_mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_io_sw,
  input  logic [DATA_W-1:0] i_io_btn,
  input  logic [ADDR_W-1:0] i_ip_addr,
  output logic [DATA_W-1:0] o_ip_data
);

  logic [DATA_W-1:0] sw_q;
  logic [DATA_W-1:0] btn_q;
  ip_sel_e           sel;
  logic [3:0]        unused_addr_lo;

  sync_2ff u_sync_sw (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .d_i   (i_io_sw),
    .q_o   (sw_q)
  );

  sync_2ff u_sync_btn (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .d_i   (i_io_btn),
    .q_o   (btn_q)
  );

  // Byte offset within a page does not affect the read.
  assign unused_addr_lo = i_ip_addr[3:0];

  assign sel = ip_decode(i_ip_addr[ADDR_W-1:4]);

  // Read mux: unmapped pages return zero.
  always_comb begin
    o_ip_data = '0;
    case (sel)
      SEL_SW:  o_ip_data = sw_q;
      SEL_BTN: o_ip_data = btn_q;
      default: o_ip_data = '0;
    endcase
  end

endmodule

// File: tb/tb_ip_mem.sv
// tb_ip_mem: scoreboard bench for ip_mem.
// Expectations are queued at drive time and popped on read.
module tb_ip_mem;

  logic        clk;
  logic        rst;
  logic [31:0] sw;
  logic [31:0] btn;
  logic [15:0] addr;
  logic [31:0] data;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks;
  int   n_fail;

  ip_mem dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_io_sw   (sw),
    .i_io_btn  (btn),
    .i_ip_addr (addr),
    .o_ip_data (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    sw   = 32'hFFFF_FFFF;
    btn  = 32'hFFFF_FFFF;
    addr = 16'h7800;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{"reset_sw", 32'h0});
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (data !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, data, e.val);
      end
    end
    addr = 16'h7810;
    exp_q.push_back('{"reset_btn", 32'h0});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (data !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, data, e.val);
    end
  endtask

  task automatic test_sw_latency();
    rst  = 1'b0;
    sw   = 32'hDEAD_BEEF;
    btn  = 32'h0;
    addr = 16'h7800;
    exp_q.push_back('{"sw_1edge", 32'h0});
    exp_q.push_back('{"sw_2edge", 32'hDEAD_BEEF});
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (data !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, data, e.val);
      end
    end
  endtask

  task automatic test_btn();
    btn  = 32'h1234_5678;
    addr = 16'h7810;
    exp_q.push_back('{"btn_1edge", 32'h0});
    exp_q.push_back('{"btn_2edge", 32'h1234_5678});
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (data !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, data, e.val);
      end
    end
    addr = 16'h781C;
    exp_q.push_back('{"btn_lowbits", 32'h1234_5678});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (data !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.name, data, e.val);
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] a_tab [6];
    logic [31:0] v_tab [6];
    a_tab = '{16'h7FFF, 16'h7820, 16'h0000,
              16'h77FF, 16'h780F, 16'h781F};
    v_tab = '{32'h0, 32'h0, 32'h0,
              32'h0, 32'hDEAD_BEEF, 32'h1234_5678};
    for (int i = 0; i < 6; i++) begin
      addr = a_tab[i];
      exp_q.push_back('{$sformatf("decode_%h", a_tab[i]), v_tab[i]});
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (data !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, data, e.val);
      end
    end
  endtask

  task automatic test_simultaneous();
    sw  = 32'hCAFE_F00D;
    btn = 32'h0BAD_C0DE;
    exp_q.push_back('{"simul_sw_old", 32'hDEAD_BEEF});
    exp_q.push_back('{"simul_btn_old", 32'h1234_5678});
    exp_q.push_back('{"simul_sw_new", 32'hCAFE_F00D});
    exp_q.push_back('{"simul_btn_new", 32'h0BAD_C0DE});
    for (int i = 0; i < 2; i++) begin
      step();
      for (int j = 0; j < 2; j++) begin
        addr = (j == 0) ? 16'h7800 : 16'h7810;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %h want %h", e.name, data, e.val);
        end
      end
    end
    sw  = 32'hDEAD_BEEF;
    btn = 32'h1234_5678;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      step();
      addr = (i % 2 == 0) ? 16'h7800 : 16'h7810;
      exp_q.push_back('{$sformatf("toggle_%0d", i),
        (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678});
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (data !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, data, e.val);
      end
    end
  endtask

  task automatic test_mid_reset();
    addr = 16'h7800;
    sw   = 32'hDEAD_BEEF;
    rst  = 1'b1;
    exp_q.push_back('{"midrst_edge", 32'h0});
    exp_q.push_back('{"midrst_rel1", 32'h0});
    exp_q.push_back('{"midrst_rel2", 32'hDEAD_BEEF});
    for (int i = 0; i < 3; i++) begin
      step();
      rst = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (data !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, data, e.val);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    sw   = '0;
    btn  = '0;
    addr = '0;
    #1;
    test_reset();
    test_sw_latency();
    test_btn();
    test_unmapped();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ip_mem.md
IP_MEM -- requirements
Module: ip_mem

Interface
REQ-001 SHALL have no parameters; all widths are fixed (data 32, address 16).
REQ-002 SHALL have port i_clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_io_sw, input, 32 bits: raw switch inputs, asynchronous to i_clk.
REQ-005 SHALL have port i_io_btn, input, 32 bits: raw button inputs, asynchronous to i_clk.
REQ-006 SHALL have port i_ip_addr, input, 16 bits: byte address of the read, combinational.
REQ-007 SHALL have port o_ip_data, output, 32 bits: read data.

Function
REQ-008 SHALL pass i_io_sw through a 2-flop synchronizer into a 32-bit switch register.
REQ-009 SHALL pass i_io_btn through a 2-flop synchronizer into a 32-bit button register.
REQ-010 SHALL make an input change applied before rising edge N visible in its register, and on o_ip_data, after rising edge N+1 (2-edge latency).
REQ-011 SHALL decode the address on i_ip_addr[15:4] only; i_ip_addr[3:0] are ignored.
REQ-012 SHALL drive o_ip_data with the switch register when i_ip_addr[15:4] is 0x780 (addresses 0x7800-0x780F).
REQ-013 SHALL drive o_ip_data with the button register when i_ip_addr[15:4] is 0x781 (addresses 0x7810-0x781F).
REQ-014 SHALL drive o_ip_data to 32'h0000_0000 for every other address, including the rest of 0x7820-0x7FFF and anything below 0x7800.
REQ-015 SHALL make the read path purely combinational from i_ip_addr and the registers: an address change is reflected in the same cycle, with no added latency.
REQ-016 SHALL be read-only: there is no write port, and reads have no side effects.
REQ-017 SHALL, when switches and buttons change in the same cycle, capture both independently with identical latency.

Reset
REQ-018 SHALL, while i_rst=1 at a rising edge, clear all synchronizer stages and both registers to 0, so every readable address returns 0.
REQ-019 SHALL give reset priority over sampling; an input change during reset is lost until it is sampled again after release.
REQ-020 SHALL restart sampling on the first rising edge with i_rst=0; data valid after 2 edges.
REQ-021 SHALL not gate o_ip_data on i_rst; decode remains combinational and simply returns the cleared register values.

Structure
REQ-022 SHALL place the base addresses (SW_BASE=0x780, BTN_BASE=0x781 on addr[15:4]) and the data and address widths in a shared package (ip_mem_pkg) for reuse by the LSU decoder.
REQ-023 SHALL implement the synchronizer as one sub-module, sync_2ff (32-bit, synchronous active-high reset), instantiated twice.

Verification
REQ-024 SHALL verify: i_rst=1 for 2 cycles with sw=0xFFFFFFFF, addr=0x7800 -> o_ip_data=0x00000000 during reset.
REQ-025 SHALL verify: i_rst=0, sw=0xDEADBEEF, addr=0x7800, wait 2 edges -> o_ip_data=0xDEADBEEF; after only 1 edge -> previous value.
REQ-026 SHALL verify: btn=0x12345678, addr=0x7810, wait 2 edges -> 0x12345678; addr=0x781C -> 0x12345678 (low bits ignored).
REQ-027 SHALL verify: addr=0x7FFF, then 0x7820, then 0x0000 -> 0x00000000 each, same cycle.
REQ-028 SHALL verify: sw and btn loaded, then addr toggled 0x7800/0x7810 every cycle -> data switches 0xDEADBEEF/0x12345678 combinationally with no lag.
REQ-029 SHALL verify: reset asserted for 1 cycle mid-operation with sw held at 0xDEADBEEF -> reads 0 after the reset edge, and 0xDEADBEEF again 2 edges after release.
